// File: rtl/fighter_pkg.sv
// Shared definitions for the fighter action sequencer: phase encodings,
// LED bit positions and one-hot direction constants.
package fighter_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    ATK_STARTUP  = 3'd1,
    ATK_ACTIVE   = 3'd2,
    ATK_RECOVERY = 3'd3,
    PARRY        = 3'd4,
    PARRY_RECOV  = 3'd5,
    HITSTUN      = 3'd6
  } phase_e;

  localparam int LED_IDLE    = 0;
  localparam int LED_DIR_LSB = 1;
  localparam int LED_HITBOX  = 5;
  localparam int LED_PARRY   = 6;

  localparam logic [3:0] CENTER = 4'b0000;
  localparam logic [3:0] LEFT   = 4'b0001;
  localparam logic [3:0] RIGHT  = 4'b0010;
  localparam logic [3:0] UP     = 4'b0100;
  localparam logic [3:0] DOWN   = 4'b1000;

  // btn is {down,up,right,left}; left > right > up > down
  function automatic logic [3:0] dir_pick(input logic [3:0] btn);
    if (btn[0])      return LEFT;
    else if (btn[1]) return RIGHT;
    else if (btn[2]) return UP;
    else if (btn[3]) return DOWN;
    else             return CENTER;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for one raw button plus a registered rising-edge pulse.
// Latency: raw rise to pulse is three clks; pulse lasts one clk.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  logic meta, sync, prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      prev <= sync;
      rise <= sync & ~prev;
    end
  end

endmodule

// File: rtl/fighter_action_sequencer.sv
// Turns synchronized controller buttons into frame-timed action phases.
// State changes on frame_tick; hit_in acts immediately; outputs lag state by one clk.
module fighter_action_sequencer
  import fighter_pkg::*;
#(
  parameter int STARTUP_FR     = 4,
  parameter int ACTIVE_FR      = 3,
  parameter int RECOVERY_FR    = 8,
  parameter int PARRY_FR       = 6,
  parameter int PARRY_RECOV_FR = 10,
  parameter int HITSTUN_FR     = 12,
  parameter int CNT_W          = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic       attack,
  input  logic       pery,
  input  logic       hit_in,
  output logic [3:0] move_dir,
  output logic       hitbox_en,
  output logic       parry_open,
  output logic       parried,
  output logic       busy,
  output logic [2:0] phase,
  output logic [6:0] led_outputs
);

  localparam logic [CNT_W-1:0] STARTUP_C     = CNT_W'(STARTUP_FR);
  localparam logic [CNT_W-1:0] ACTIVE_C      = CNT_W'(ACTIVE_FR);
  localparam logic [CNT_W-1:0] RECOVERY_C    = CNT_W'(RECOVERY_FR);
  localparam logic [CNT_W-1:0] PARRY_C       = CNT_W'(PARRY_FR);
  localparam logic [CNT_W-1:0] PARRY_RECOV_C = CNT_W'(PARRY_RECOV_FR);
  localparam logic [CNT_W-1:0] HITSTUN_C     = CNT_W'(HITSTUN_FR);

  logic [3:0]       dir_meta, dir_sync;
  logic             atk_rise, pry_rise;
  logic             atk_pend, pry_pend;
  phase_e           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_meta <= 4'b0;
      dir_sync <= 4'b0;
    end else begin
      dir_meta <= {down, up, right, left};
      dir_sync <= dir_meta;
    end
  end

  btn_sync_edge u_atk_sync (.clk(clk), .rst_n(rst_n), .raw(attack), .rise(atk_rise));
  btn_sync_edge u_pry_sync (.clk(clk), .rst_n(rst_n), .raw(pery),   .rise(pry_rise));

  // A press survives only until the next tick; a rise on the tick clk itself
  // becomes the press for the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      atk_pend <= 1'b0;
      pry_pend <= 1'b0;
    end else if (frame_tick) begin
      atk_pend <= atk_rise;
      pry_pend <= pry_rise;
    end else begin
      atk_pend <= atk_pend | atk_rise;
      pry_pend <= pry_pend | pry_rise;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      phase      <= IDLE;
      busy       <= 1'b0;
      hitbox_en  <= 1'b0;
      parry_open <= 1'b0;
      parried    <= 1'b0;
      move_dir   <= CENTER;
    end else begin
      parried <= 1'b0;
      if (hit_in && state != HITSTUN) begin
        if (state == PARRY) begin
          parried <= 1'b1;
          state   <= IDLE;
          cnt     <= '0;
        end else begin
          state <= HITSTUN;
          cnt   <= HITSTUN_C;
        end
      end else if (frame_tick) begin
        if (state == IDLE) begin
          if (pry_pend) begin
            state <= PARRY;
            cnt   <= PARRY_C;
          end else if (atk_pend) begin
            state <= ATK_STARTUP;
            cnt   <= STARTUP_C;
          end
        end else if (cnt > 1) begin
          cnt <= cnt - 1'b1;
        end else begin
          case (state)
            ATK_STARTUP: begin state <= ATK_ACTIVE;   cnt <= ACTIVE_C;      end
            ATK_ACTIVE:  begin state <= ATK_RECOVERY; cnt <= RECOVERY_C;    end
            PARRY:       begin state <= PARRY_RECOV;  cnt <= PARRY_RECOV_C; end
            default:     begin state <= IDLE;         cnt <= '0;            end
          endcase
        end
      end

      phase      <= state;
      busy       <= (state != IDLE);
      hitbox_en  <= (state == ATK_ACTIVE);
      parry_open <= (state == PARRY);
      move_dir   <= (state == IDLE) ? dir_pick(dir_sync) : CENTER;
    end
  end

  // Idle LED lights only when standing still so the bus stays one-hot.
  always_comb begin
    led_outputs                           = 7'b0;
    led_outputs[LED_IDLE]                 = (phase == IDLE) && (move_dir == CENTER);
    led_outputs[LED_DIR_LSB+3:LED_DIR_LSB] = move_dir;
    led_outputs[LED_HITBOX]               = hitbox_en;
    led_outputs[LED_PARRY]                = parry_open;
  end

endmodule
